// File: rtl/sha1_w_schedule.sv
// sha1_w_schedule: SHA-1 message-schedule front end, expands one 512-bit block into W[0..79].
//
// Ports:
//   clk, rst_n       rising-edge clock, synchronous active-low reset
//   blk_valid/ready  block handshake; blk_data[511:480] is word 0, blk_channel is the tag
//   w_valid/ready    word handshake; w_data = W[t], w_round = t, w_channel = latched tag,
//                    w_last marks round 79
//
// Build option: define SHA1_W_BYTESWAP_EN to byte-reverse each input word at load
// (little-endian hosts). Expansion and timing do not change.
module sha1_w_schedule #(
  parameter int DATA_WIDTH        = 32,
  parameter int CHANNEL_NUM_TOTAL = 64,
  parameter int CHANNEL_NUM_WIDTH = $clog2(CHANNEL_NUM_TOTAL)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         blk_valid,
  output logic                         blk_ready,
  input  logic [16*DATA_WIDTH-1:0]     blk_data,
  input  logic [CHANNEL_NUM_WIDTH-1:0] blk_channel,
  output logic                         w_valid,
  input  logic                         w_ready,
  output logic [DATA_WIDTH-1:0]        w_data,
  output logic [6:0]                   w_round,
  output logic [CHANNEL_NUM_WIDTH-1:0] w_channel,
  output logic                         w_last
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t                         state_q, state_d;
  logic [DATA_WIDTH-1:0]          win_q [16];
  logic [DATA_WIDTH-1:0]          win_d [16];
  logic [6:0]                     round_q, round_d;
  logic [CHANNEL_NUM_WIDTH-1:0]   chan_q, chan_d;
  logic [DATA_WIDTH-1:0]          mix;
  logic                           load, adv, done;

  function automatic logic [DATA_WIDTH-1:0] in_word(input logic [DATA_WIDTH-1:0] x);
`ifdef SHA1_W_BYTESWAP_EN
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
    return x;
`endif
  endfunction

  assign load      = state_q == IDLE && blk_valid;
  assign adv       = state_q == RUN && w_ready;
  assign done      = adv && round_q == 7'd79;
  assign mix       = win_q[13] ^ win_q[8] ^ win_q[2] ^ win_q[0];
  assign blk_ready = state_q == IDLE;
  assign w_valid   = state_q == RUN;
  assign w_data    = win_q[0];
  assign w_round   = round_q;
  assign w_channel = chan_q;
  assign w_last    = w_valid && round_q == 7'd79;

  always_comb begin
    state_d = load ? RUN : done ? IDLE : state_q;
    // cleared on the final advance too, so the counter never passes 79
    round_d = (load || done) ? 7'd0 : adv ? round_q + 7'd1 : round_q;
    chan_d  = load ? blk_channel : chan_q;
    for (int i = 0; i < 15; i++)
      win_d[i] = load ? in_word(blk_data[(15-i)*DATA_WIDTH +: DATA_WIDTH]) : adv ? win_q[i+1] : win_q[i];
    win_d[15] = load ? in_word(blk_data[DATA_WIDTH-1:0]) : adv ? {mix[DATA_WIDTH-2:0], mix[DATA_WIDTH-1]} : win_q[15];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      round_q <= '0;
      chan_q  <= '0;
      win_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      chan_q  <= chan_d;
      win_q   <= win_d;
    end
  end
endmodule

// File: tb/tb_sha1_w_schedule.sv
// tb_sha1_w_schedule: randomized self-checking bench for sha1_w_schedule against a plain SHA-1 schedule model.
module tb_sha1_w_schedule;
  logic         clk = 0, rst_n = 0, blk_valid = 0, w_ready = 0;
  logic [511:0] blk_data = '0;
  logic [5:0]   blk_channel = '0;
  logic         blk_ready, w_valid, w_last;
  logic [31:0]  w_data;
  logic [6:0]   w_round;
  logic [5:0]   w_channel;
  int           checks = 0, errors = 0;
  logic [31:0]  wref [80];
  logic [31:0]  got  [80];
  logic [511:0] nxt_blk;
  logic [5:0]   nxt_ch;

  sha1_w_schedule dut (
    .clk(clk), .rst_n(rst_n), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_data(blk_data), .blk_channel(blk_channel), .w_valid(w_valid), .w_ready(w_ready),
    .w_data(w_data), .w_round(w_round), .w_channel(w_channel), .w_last(w_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] swap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [31:0] rotl1(input logic [31:0] x);
    return (x << 1) | (x >> 31);
  endfunction

  task automatic model(input logic [511:0] b);
    for (int i = 0; i < 16; i++) begin
      wref[i] = b >> (32 * (15 - i));
`ifdef SHA1_W_BYTESWAP_EN
      wref[i] = swap(wref[i]);
`endif
    end
    for (int t = 16; t < 80; t++)
      wref[t] = rotl1(wref[t-3] ^ wref[t-8] ^ wref[t-14] ^ wref[t-16]);
  endtask

  function automatic logic [511:0] host_blk(input logic [31:0] w [16]);
    logic [511:0] b = '0;
    for (int i = 0; i < 16; i++) begin
`ifdef SHA1_W_BYTESWAP_EN
      b = (b << 32) | 512'(swap(w[i]));
`else
      b = (b << 32) | 512'(w[i]);
`endif
    end
    return b;
  endfunction

  function automatic logic [511:0] rand_blk();
    logic [511:0] b = '0;
    for (int i = 0; i < 16; i++) b = (b << 32) | 512'($urandom);
    return b;
  endfunction

  // Called at a negedge with word t=0 presented; checks words until stop_at.
  task automatic stream(input logic [5:0] ch, input bit bp, input int stop_at, input int pulse_at);
    int  t = 0, cyc = 0;
    bit  rdy;
    while (t < stop_at) begin
      if (cyc++ > 2000) begin
        check("timeout", 1, 0);
        break;
      end
      if (t == pulse_at) begin
        blk_valid = 1; blk_data = nxt_blk; blk_channel = nxt_ch;
      end
      check($sformatf("valid_r%0d", t), w_valid, 1);
      check($sformatf("data_r%0d", t), w_data, wref[t]);
      check($sformatf("round_r%0d", t), w_round, t);
      check($sformatf("chan_r%0d", t), w_channel, ch);
      check($sformatf("last_r%0d", t), w_last, t == 79);
      check($sformatf("bready_r%0d", t), blk_ready, 0);
      got[t] = w_data;
      rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      w_ready = rdy;
      @(negedge clk);
      if (rdy) t++;
    end
    if (stop_at == 80) begin
      check("bubble_valid", w_valid, 0);
      check("bubble_ready", blk_ready, 1);
      check("bubble_last", w_last, 0);
    end
  endtask

  task automatic present(input logic [511:0] b, input logic [5:0] ch);
    check("present_ready", blk_ready, 1);
    model(b);
    blk_valid = 1; blk_data = b; blk_channel = ch;
    @(negedge clk);
    blk_valid = 0;
  endtask

  initial begin
    logic [31:0] abc [16];
    logic [511:0] a, b;
    foreach (abc[i]) abc[i] = 0;
    abc[0] = 32'h61626380;
    abc[15] = 32'h00000018;
    w_ready = 1;
    repeat (2) @(negedge clk);
    check("rst_ready", blk_ready, 1);
    check("rst_valid", w_valid, 0);
    check("rst_last", w_last, 0);
    check("rst_round", w_round, 0);
    check("rst_chan", w_channel, 0);
    check("rst_data", w_data, 0);
    rst_n = 1;
    @(negedge clk);
    check("idle_valid", w_valid, 0);

    present(host_blk(abc), 5);
    stream(5, 0, 80, -1);
    check("abc_w0", got[0], 32'h61626380);
    check("abc_w1", got[1], 0);
    check("abc_w15", got[15], 32'h00000018);
    check("abc_w16", got[16], 32'hC2C4C700);
    check("abc_w17", got[17], 0);
    check("abc_w18", got[18], 32'h00000030);

    present(host_blk(abc), 7);
    stream(7, 1, 80, -1);

    repeat (3) begin
      present(rand_blk(), 6'($urandom));
      stream(w_channel, 1, 80, -1);
    end

    a = rand_blk(); b = rand_blk();
    model(a);
    blk_valid = 1; blk_data = a; blk_channel = 1;
    @(negedge clk);
    blk_data = b; blk_channel = 2;
    stream(1, 0, 80, -1);
    model(b);
    @(negedge clk);
    blk_valid = 0;
    stream(2, 0, 80, -1);

    nxt_blk = rand_blk(); nxt_ch = 4;
    present(rand_blk(), 3);
    stream(3, 1, 80, 20);
    check("pending_valid", blk_valid, 1);
    model(nxt_blk);
    @(negedge clk);
    blk_valid = 0;
    stream(4, 0, 80, -1);

    present(rand_blk(), 9);
    stream(9, 1, 40, -1);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    check("abort_valid", w_valid, 0);
    check("abort_ready", blk_ready, 1);
    check("abort_round", w_round, 0);
    @(negedge clk);
    check("abort_idle", w_valid, 0);
    present(rand_blk(), 10);
    stream(10, 0, 80, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
